// File: rtl/dfe_sslms_adapt.sv
// Sign-sign LMS adaptation engine for an N-tap DFE: correlates the error sign with past
// decisions, integrates saturating per-tap weights, and bounds training with a small FSM.
module dfe_sslms_adapt #(
  parameter int unsigned Ntap = 2,
  parameter int unsigned Wtap = 6,
  parameter int unsigned Wacc = 12,
  parameter int unsigned Wcnt = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   freeze_i,
  input  logic                   clear_i,
  input  logic [2:0]             mu_i,
  input  logic [Wcnt-1:0]        n_upd_i,
  input  logic                   valid_i,
  input  logic                   data_i,
  input  logic                   err_i,
  output logic [Ntap*Wtap-1:0]   wtap_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [Ntap-1:0]        sat_o
);

  typedef enum logic [1:0] {StIdle, StTrain, StHold} state_e;

  localparam int unsigned MuMax = Wacc - 2;
  localparam logic signed [Wacc:0] AccMax = (Wacc+1)'((1 << (Wacc - 1)) - 1);
  localparam logic signed [Wacc:0] AccMin = (Wacc+1)'(-(1 << (Wacc - 1)));

  state_e                 state_q;
  logic                   busy_q, done_q;
  logic [Wcnt-1:0]        cnt_q, cnt_inc;
  logic [Ntap-1:0]        hist_q, hist_d;
  logic [Ntap-1:0]        sat_q, sat_d;
  logic signed [Wacc-1:0] acc_q [Ntap];
  logic signed [Wacc-1:0] acc_d [Ntap];
  logic signed [Wacc:0]   step;
  logic signed [Wacc:0]   sum;
  logic                   upd_en;

  assign upd_en  = (state_q == StTrain) && valid_i && !freeze_i;
  assign cnt_inc = cnt_q + Wcnt'(1);
  // Newest decision enters at bit 0; the oldest falls off the top.
  assign hist_d  = valid_i ? Ntap'({hist_q, data_i}) : hist_q;

  always_comb begin
    if (32'(mu_i) > MuMax) begin
      step = (Wacc+1)'(1) << MuMax;
    end else begin
      step = (Wacc+1)'(1) << mu_i;
    end
  end

  // One extra bit of headroom lets the clamp detect overflow in either direction.
  always_comb begin
    sum = '0;
    for (int k = 0; k < int'(Ntap); k++) begin
      acc_d[k] = acc_q[k];
      sat_d[k] = sat_q[k];
      if (clear_i) begin
        acc_d[k] = '0;
        sat_d[k] = 1'b0;
      end else if (upd_en) begin
        if (err_i == hist_q[k]) begin
          sum = $signed({acc_q[k][Wacc-1], acc_q[k]}) + step;
        end else begin
          sum = $signed({acc_q[k][Wacc-1], acc_q[k]}) - step;
        end
        if (sum > AccMax) begin
          acc_d[k] = AccMax[Wacc-1:0];
          sat_d[k] = 1'b1;
        end else if (sum < AccMin) begin
          acc_d[k] = AccMin[Wacc-1:0];
          sat_d[k] = 1'b1;
        end else begin
          acc_d[k] = sum[Wacc-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= '0;
      sat_q  <= '0;
      for (int k = 0; k < int'(Ntap); k++) acc_q[k] <= '0;
    end else begin
      hist_q <= hist_d;
      sat_q  <= sat_d;
      for (int k = 0; k < int'(Ntap); k++) acc_q[k] <= acc_d[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle, StHold: begin
          if (start_i) begin
            cnt_q <= '0;
            if (n_upd_i == '0) begin
              state_q <= StHold;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StTrain;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        StTrain: begin
          if (upd_en) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == n_upd_i) begin
              state_q <= StHold;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < int'(Ntap); k++) begin : g_wtap
    assign wtap_o[k*Wtap +: Wtap] = acc_q[k][Wacc-1 -: Wtap];
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sat_o  = sat_q;

endmodule
